// File: rtl/path_ctrl_pkg.sv
// Shared state encoding and the default address map used by the path-planning firmware.
package path_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_START = 2'd1,
        WR_END   = 2'd2,
        RUN      = 2'd3
    } ctrl_state_t;

    // Must match the firmware's linker/header addresses.
    localparam logic [31:0] DEF_START_ADDR = 32'h0200_0000;
    localparam logic [31:0] DEF_END_ADDR   = 32'h0200_0004;
    localparam logic [31:0] DEF_PATH_ADDR  = 32'h0200_0008;
    localparam logic [31:0] DEF_DONE_ADDR  = 32'h0200_000C;
    localparam logic [31:0] DEF_LEN_ADDR   = 32'h0200_00E0;

endpackage

// File: rtl/path_node_buffer.sv
// Path node capture buffer: sequential slot fill, clear, and sticky overflow on a store to a full buffer.
module path_node_buffer #(
    parameter int NODE_W    = 5,
    parameter int MAX_NODES = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [NODE_W-1:0]           wr_data,
    output logic [MAX_NODES*NODE_W-1:0] node_values,
    output logic                        overflow
);

    localparam int IDX_W = $clog2(MAX_NODES + 1);

    logic [IDX_W-1:0] index;
    logic             full;

    assign full = (index == IDX_W'(MAX_NODES));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            index    <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            if (full) overflow <= 1'b1;
            else      index    <= index + IDX_W'(1);
        end
    end

    for (genvar k = 0; k < MAX_NODES; k++) begin : g_slot
        logic [NODE_W-1:0] slot_q;

        always_ff @(posedge clk) begin
            if (reset || clear)
                slot_q <= '0;
            else if (wr_en && !full && index == IDX_W'(k))
                slot_q <= wr_data;
        end

        assign node_values[k*NODE_W +: NODE_W] = slot_q;
    end

endmodule

// File: rtl/path_capture_ctrl.sv
// Host-side controller: loads (start,end) into the core, runs it, and captures the path it stores back.
module path_capture_ctrl
    import path_ctrl_pkg::*;
#(
    parameter int          NODE_W         = 5,
    parameter int          MAX_NODES      = 12,
    parameter int          LEN_W          = 4,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [31:0] START_ADDR     = DEF_START_ADDR,
    parameter logic [31:0] END_ADDR       = DEF_END_ADDR,
    parameter logic [31:0] PATH_ADDR      = DEF_PATH_ADDR,
    parameter logic [31:0] DONE_ADDR      = DEF_DONE_ADDR,
    parameter logic [31:0] LEN_ADDR       = DEF_LEN_ADDR
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NODE_W-1:0]           start_node,
    input  logic [NODE_W-1:0]           end_node,
    input  logic                        mem_write,
    input  logic [31:0]                 riscv_rd_addr,
    input  logic [31:0]                 riscv_rd_data,
    output logic                        cpu_reset,
    output logic                        ext_mem_wrt,
    output logic [31:0]                 ext_data_addr,
    output logic [31:0]                 ext_wrt_data,
    output logic [MAX_NODES*NODE_W-1:0] node_values,
    output logic [LEN_W-1:0]            path_length,
    output logic                        path_valid,
    output logic                        busy,
    output logic                        overflow,
    output logic                        timeout
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ctrl_state_t       state;
    logic              init_pend;
    logic [NODE_W-1:0] start_q, end_q;
    logic [TMR_W-1:0]  timer;
    logic              node_chg, restart, run_st, path_st, len_st, done_st;

    // A node change from any state restarts; init_pend forces one run after reset.
    assign node_chg = (start_node != start_q) || (end_node != end_q);
    assign restart  = node_chg || (state == IDLE && init_pend);
    assign run_st   = (state == RUN) && mem_write;
    assign path_st  = run_st && (riscv_rd_addr == PATH_ADDR) && !restart;
    assign len_st   = run_st && (riscv_rd_addr == LEN_ADDR);
    assign done_st  = run_st && (riscv_rd_addr == DONE_ADDR) && (riscv_rd_data == 32'd1);

    path_node_buffer #(
        .NODE_W    (NODE_W),
        .MAX_NODES (MAX_NODES)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (restart),
        .wr_en       (path_st),
        .wr_data     (riscv_rd_data[NODE_W-1:0]),
        .node_values (node_values),
        .overflow    (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            init_pend     <= 1'b1;
            start_q       <= '0;
            end_q         <= '0;
            timer         <= '0;
            cpu_reset     <= 1'b1;
            ext_mem_wrt   <= 1'b0;
            ext_data_addr <= '0;
            ext_wrt_data  <= '0;
            path_length   <= '0;
            path_valid    <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
        end else if (restart) begin
            state         <= WR_START;
            init_pend     <= 1'b0;
            start_q       <= start_node;
            end_q         <= end_node;
            timer         <= '0;
            cpu_reset     <= 1'b1;
            ext_mem_wrt   <= 1'b1;
            ext_data_addr <= START_ADDR;
            ext_wrt_data  <= 32'(start_node);
            path_length   <= '0;
            path_valid    <= 1'b0;
            busy          <= 1'b1;
            timeout       <= 1'b0;
        end else begin
            case (state)
                WR_START: begin
                    state         <= WR_END;
                    ext_data_addr <= END_ADDR;
                    ext_wrt_data  <= 32'(end_q);
                end
                WR_END: begin
                    state       <= RUN;
                    cpu_reset   <= 1'b0;
                    ext_mem_wrt <= 1'b0;
                end
                RUN: begin
                    if (len_st) path_length <= riscv_rd_data[LEN_W-1:0];
                    if (done_st) begin
                        state      <= IDLE;
                        path_valid <= 1'b1;
                        cpu_reset  <= 1'b1;
                        busy       <= 1'b0;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        timeout   <= 1'b1;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_capture_ctrl.sv
// Bench for path_capture_ctrl: directed table, corner-case sequences, and random traffic vs. a queue-based model.
module tb_path_capture_ctrl;

    localparam int NW = 5;
    localparam int MN = 12;
    localparam int LW = 4;
    localparam int TO = 50;
    localparam logic [31:0] A_START = 32'h0200_0000;
    localparam logic [31:0] A_END   = 32'h0200_0004;
    localparam logic [31:0] A_PATH  = 32'h0200_0008;
    localparam logic [31:0] A_DONE  = 32'h0200_000C;
    localparam logic [31:0] A_LEN   = 32'h0200_00E0;
    localparam int P_IDLE = 0, P_WS = 1, P_WE = 2, P_RUN = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     start_node, end_node;
    logic              mem_write;
    logic [31:0]       rd_addr, rd_data;
    logic              cpu_reset, ext_mem_wrt, path_valid, busy, overflow, timeout;
    logic [31:0]       ext_data_addr, ext_wrt_data;
    logic [MN*NW-1:0]  node_values;
    logic [LW-1:0]     path_length;

    always #5 clk = ~clk;

    path_capture_ctrl #(
        .NODE_W(NW), .MAX_NODES(MN), .LEN_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start_node(start_node), .end_node(end_node),
        .mem_write(mem_write), .riscv_rd_addr(rd_addr), .riscv_rd_data(rd_data),
        .cpu_reset(cpu_reset), .ext_mem_wrt(ext_mem_wrt), .ext_data_addr(ext_data_addr),
        .ext_wrt_data(ext_wrt_data), .node_values(node_values), .path_length(path_length),
        .path_valid(path_valid), .busy(busy), .overflow(overflow), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run phase, latched pair, captured nodes as a queue, run-cycle count.
    int        m_phase = P_IDLE, ms = 0, me = 0, m_len = 0, m_run = 0;
    bit        m_pend = 1, m_ovf = 0, m_vld = 0, m_tmo = 0, m_cpu = 1, m_wr = 0;
    logic [31:0] m_ea = 0, m_ed = 0;
    int        m_nodes[$];

    function automatic logic [MN*NW-1:0] model_nodes();
        logic [MN*NW-1:0] v = '0;
        for (int i = 0; i < m_nodes.size(); i++) v[i*NW +: NW] = NW'(m_nodes[i]);
        return v;
    endfunction

    task automatic model_step();
        bit chg;
        if (reset) begin
            m_phase = P_IDLE; m_pend = 1; ms = 0; me = 0; m_nodes.delete();
            m_ovf = 0; m_vld = 0; m_tmo = 0; m_cpu = 1; m_wr = 0;
            m_len = 0; m_run = 0; m_ea = 0; m_ed = 0;
        end else begin
            chg = (int'(start_node) != ms) || (int'(end_node) != me);
            if (chg || (m_phase == P_IDLE && m_pend)) begin
                m_phase = P_WS; m_pend = 0; ms = int'(start_node); me = int'(end_node);
                m_nodes.delete(); m_ovf = 0; m_vld = 0; m_tmo = 0; m_len = 0; m_run = 0;
                m_cpu = 1; m_wr = 1; m_ea = A_START; m_ed = ms;
            end else begin
                case (m_phase)
                    P_WS: begin m_phase = P_WE; m_ea = A_END; m_ed = me; end
                    P_WE: begin m_phase = P_RUN; m_cpu = 0; m_wr = 0; end
                    P_RUN: begin
                        m_run++;
                        if (mem_write && rd_addr == A_PATH) begin
                            if (m_nodes.size() < MN) m_nodes.push_back(int'(rd_data % 32));
                            else m_ovf = 1;
                        end
                        if (mem_write && rd_addr == A_LEN) m_len = int'(rd_data % 16);
                        if (mem_write && rd_addr == A_DONE && rd_data == 32'd1) begin
                            m_phase = P_IDLE; m_vld = 1; m_cpu = 1;
                        end else if (m_run == TO) begin
                            m_phase = P_IDLE; m_tmo = 1; m_cpu = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_cmp();
        chk("m_cpu_reset", cpu_reset, m_cpu);
        chk("m_ext_mem_wrt", ext_mem_wrt, m_wr);
        if (m_wr) begin
            chk("m_ext_data_addr", ext_data_addr, m_ea);
            chk("m_ext_wrt_data", ext_wrt_data, m_ed);
        end
        chk("m_node_values", node_values, model_nodes());
        chk("m_path_length", path_length, m_len);
        chk("m_path_valid", path_valid, m_vld);
        chk("m_busy", busy, m_phase != P_IDLE);
        chk("m_overflow", overflow, m_ovf);
        chk("m_timeout", timeout, m_tmo);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; rd_addr = a; rd_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    typedef struct {
        logic [NW-1:0] s, e;
        logic          mw;
        logic [31:0]   a, d;
        logic          cpu, wr;
        logic [31:0]   ea, ed;
        logic          bsy, vld;
        logic [LW-1:0] len;
    } vec_t;

    vec_t vecs[10];
    logic [MN*NW-1:0] ev;

    initial begin
        vecs[0] = '{5'd3, 5'd17, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, A_START, 32'd3,  1'b1, 1'b0, 4'd0};
        vecs[1] = '{5'd3, 5'd17, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, A_END,   32'd17, 1'b1, 1'b0, 4'd0};
        vecs[2] = '{5'd3, 5'd17, 1'b0, 32'd0,  32'd0, 1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd0};
        vecs[3] = '{5'd3, 5'd17, 1'b1, A_PATH, 32'd3, 1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd0};
        vecs[4] = '{5'd3, 5'd17, 1'b1, A_PATH, 32'd8, 1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd0};
        vecs[5] = '{5'd3, 5'd17, 1'b1, A_PATH, 32'd17,1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd0};
        vecs[6] = '{5'd3, 5'd17, 1'b1, A_LEN,  32'd3, 1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd3};
        vecs[7] = '{5'd3, 5'd17, 1'b1, A_DONE, 32'd2, 1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 4'd3};
        vecs[8] = '{5'd3, 5'd17, 1'b1, A_DONE, 32'd1, 1'b1, 1'b0, 32'd0,   32'd0,  1'b0, 1'b1, 4'd3};
        vecs[9] = '{5'd3, 5'd17, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'd0,   32'd0,  1'b0, 1'b1, 4'd3};

        // Reset state
        reset = 1'b1; start_node = 5'd3; end_node = 5'd17;
        mem_write = 1'b0; rd_addr = '0; rd_data = '0;
        tick(); tick();
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_ext_mem_wrt", ext_mem_wrt, 1'b0);
        chk("rst_ext_data_addr", ext_data_addr, 32'd0);
        chk("rst_ext_wrt_data", ext_wrt_data, 32'd0);
        chk("rst_node_values", node_values, 64'd0);
        chk("rst_path_length", path_length, 4'd0);
        chk("rst_path_valid", path_valid, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        reset = 1'b0;

        // Directed table: initial run with start=3, end=17
        for (int i = 0; i < 10; i++) begin
            start_node = vecs[i].s; end_node = vecs[i].e;
            mem_write = vecs[i].mw; rd_addr = vecs[i].a; rd_data = vecs[i].d;
            tick();
            chk($sformatf("tbl%0d_cpu_reset", i), cpu_reset, vecs[i].cpu);
            chk($sformatf("tbl%0d_ext_mem_wrt", i), ext_mem_wrt, vecs[i].wr);
            if (vecs[i].wr) begin
                chk($sformatf("tbl%0d_ext_data_addr", i), ext_data_addr, vecs[i].ea);
                chk($sformatf("tbl%0d_ext_wrt_data", i), ext_wrt_data, vecs[i].ed);
            end
            chk($sformatf("tbl%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("tbl%0d_path_valid", i), path_valid, vecs[i].vld);
            chk($sformatf("tbl%0d_path_length", i), path_length, vecs[i].len);
        end
        mem_write = 1'b0;
        chk("tbl_slot0", node_values[0*NW +: NW], 5'd3);
        chk("tbl_slot1", node_values[1*NW +: NW], 5'd8);
        chk("tbl_slot2", node_values[2*NW +: NW], 5'd17);
        chk("tbl_slots_rest", node_values[MN*NW-1:3*NW], 64'd0);

        // Overflow: 13 stores into a 12-deep buffer, DONE still completes
        start_node = 5'd4; end_node = 5'd9;
        tick(); tick(); tick();
        chk("ovf_in_run", cpu_reset, 1'b0);
        ev = '0;
        for (int k = 0; k < 13; k++) begin
            store(A_PATH, 32'(k + 1));
            if (k < MN) ev[k*NW +: NW] = NW'(k + 1);
        end
        chk("ovf_nodes", node_values, ev);
        chk("ovf_flag", overflow, 1'b1);
        store(A_DONE, 32'd1);
        chk("ovf_done_valid", path_valid, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);

        // Timeout: exactly TO cycles of RUN without DONE
        start_node = 5'd6; end_node = 5'd2;
        tick(); tick(); tick();
        chk("to_run_entry", cpu_reset, 1'b0);
        for (int c = 0; c < TO - 1; c++) tick();
        chk("to_not_yet_busy", busy, 1'b1);
        chk("to_not_yet_flag", timeout, 1'b0);
        tick();
        chk("to_flag", timeout, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_valid", path_valid, 1'b0);
        chk("to_cpu_reset", cpu_reset, 1'b1);

        // end_node change five cycles into RUN discards the run
        end_node = 5'd11;
        tick(); tick(); tick();
        store(A_PATH, 32'd7); store(A_PATH, 32'd9); tick(); tick(); tick();
        end_node = 5'd12;
        tick();
        chk("chg_cleared", node_values, 64'd0);
        chk("chg_ws_wr", ext_mem_wrt, 1'b1);
        chk("chg_ws_addr", ext_data_addr, A_START);
        chk("chg_ws_data", ext_wrt_data, 32'd6);
        tick();
        chk("chg_we_addr", ext_data_addr, A_END);
        chk("chg_we_data", ext_wrt_data, 32'd12);
        tick();
        chk("chg_run", cpu_reset, 1'b0);
        chk("chg_no_stale", node_values, 64'd0);

        // DONE coincident with start change: restart wins
        start_node = 5'd7;
        store(A_DONE, 32'd1);
        chk("coin_valid", path_valid, 1'b0);
        chk("coin_ws_addr", ext_data_addr, A_START);
        chk("coin_ws_data", ext_wrt_data, 32'd7);
        chk("coin_busy", busy, 1'b1);
        tick(); tick();
        store(A_DONE, 32'd1);
        chk("coin_then_done", path_valid, 1'b1);

        // Reset mid-run, then the forced initial run
        start_node = 5'd1;
        tick(); tick(); tick();
        store(A_PATH, 32'd5); store(A_LEN, 32'd1);
        reset = 1'b1;
        tick();
        chk("mrst_cpu_reset", cpu_reset, 1'b1);
        chk("mrst_nodes", node_values, 64'd0);
        chk("mrst_len", path_length, 4'd0);
        reset = 1'b0;
        tick();
        chk("mrst_restart_wr", ext_mem_wrt, 1'b1);
        chk("mrst_restart_data", ext_wrt_data, 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 59) == 0) begin
                start_node = NW'($urandom); end_node = NW'($urandom);
            end
            mem_write = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0, 1, 2, 3: rd_addr = A_PATH;
                4:          rd_addr = A_LEN;
                5:          rd_addr = A_DONE;
                6:          rd_addr = A_START;
                default:    rd_addr = $urandom;
            endcase
            if (rd_addr == A_DONE) rd_data = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom_range(0, 3));
            else                   rd_data = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
